// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//
// Shared definitions for the push-button conditioning stage that feeds the
// sequence-generator FSM's x input.
//
// Contents:
//   - Default values for the synchronizer depth, the debounce length and the
//     stability counter width.
//   - The 2-bit debounce FSM state encoding.
//
// Configuration macro used by the consumers of this package:
//   DEBOUNCE_RELEASE_PULSE_EN - when defined, btn_debounce_fsm drives a
//                               one-cycle x_release pulse on an accepted 1->0
//                               change; otherwise x_release is tied to 0.
// -----------------------------------------------------------------------------
package debounce_pkg;

  // Default number of synchronizer flops on the raw input (legal 2..4).
  localparam int unsigned SYNC_STAGES_DEF     = 2;
  // Default number of consecutive stable samples needed to accept a change.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  // Default width of the stability counter.
  localparam int unsigned CNT_W_DEF           = 8;

  // Debounce FSM states. The IDLE_* states hold an accepted level; the WAIT_*
  // states are qualifying a candidate change towards the named level.
  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

endpackage : debounce_pkg

// File: rtl/btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
//
// Multi-flop synchronizer for a single asynchronous input. The raw level is
// shifted through STAGES flops; only the last one is presented to the rest of
// the clock domain. Reusable for any other raw input in the design.
//
// Parameters:
//   STAGES  number of flops in the chain (legal 2..4)
//
// Ports:
//   clk     input  system clock, rising-edge active
//   reset   input  asynchronous, active-high reset; clears the whole chain
//   d       input  raw asynchronous level
//   q       output synchronized level (last flop of the chain)
// -----------------------------------------------------------------------------
module btn_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Bit 0 captures the raw input; every later bit takes its predecessor.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: registers are updated with non-blocking assignments so every flop in
  // the chain samples the value its predecessor held before this edge; a
  // blocking update would collapse the chain into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : btn_sync

// File: rtl/btn_debounce_fsm.sv
// -----------------------------------------------------------------------------
// btn_debounce_fsm
//
// Conditions a raw, bouncing push-button/switch into a clean clk-synchronous
// level (x_level) for the downstream sequence-generator FSM, plus one-cycle
// pulses on accepted edges.
//
// Structure:
//   btn_raw -> btn_sync (SYNC_STAGES flops) -> sync_q -> 4-state debounce FSM
//   with a stability counter -> registered x_level / x_press / x_release.
//
// A candidate level change is accepted only after DEBOUNCE_CYCLES consecutive
// samples of the new level at sync_q. x_level therefore moves on edge
// SYNC_STAGES + DEBOUNCE_CYCLES after the first edge that samples the new raw
// level. Any sample of the old level while waiting abandons the candidate.
//
// Parameters:
//   SYNC_STAGES      synchronizer depth (legal 2..4)
//   DEBOUNCE_CYCLES  stable samples needed to accept (legal 2..2**CNT_W-1)
//   CNT_W            stability counter width
//
// Ports:
//   clk        input  system clock, rising-edge active
//   reset      input  asynchronous, active-high reset
//   btn_raw    input  raw asynchronous button/switch level
//   x_level    output debounced, synchronized level
//   x_press    output one-clk pulse on an accepted 0->1 change
//   x_release  output one-clk pulse on an accepted 1->0 change
//
// Configuration macro:
//   DEBOUNCE_RELEASE_PULSE_EN - defined: x_release pulses on the same edge that
//   x_level falls. Undefined: x_release is constant 0. State transitions and
//   x_level are identical in both builds.
// -----------------------------------------------------------------------------
module btn_debounce_fsm
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic x_level,
  output logic x_press,
  output logic x_release
);

  // Terminal count: the counter holds the number of stable samples already
  // seen minus the one being evaluated, so acceptance happens at N-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Synchronizer: the only consumer of btn_raw.
  // ---------------------------------------------------------------------------
  logic sync_q;

  btn_sync #(
    .STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (sync_q)
  );

  // ---------------------------------------------------------------------------
  // FSM / counter / output registers
  // ---------------------------------------------------------------------------
  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             x_level_q, x_level_d;
  logic             x_press_q, x_press_d;

  // Acceptance conditions, shared by the next-state and output processes so
  // the level, the pulse and the state change can never disagree.
  logic accept_hi;
  logic accept_lo;

  assign accept_hi = (state_q == WAIT_HI) &&  sync_q && (cnt_q == CNT_LAST);
  assign accept_lo = (state_q == WAIT_LO) && !sync_q && (cnt_q == CNT_LAST);

  // State register (process 1 of 3). A reset in the middle of a WAIT state
  // simply drops the candidate: no pulse is ever generated from reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE_LO;
      cnt_q     <= '0;
      x_level_q <= 1'b0;
      x_press_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_level_q <= x_level_d;
      x_press_q <= x_press_d;
    end
  end

  // Next-state and counter logic (process 2 of 3). The counter is cleared on
  // every transition and only advances while a WAIT state is still short of
  // the terminal count, so it can neither exceed CNT_LAST nor wrap.
  always_comb begin
    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a
    // latch.
    state_d = state_q;
    cnt_d   = '0;

    case (state_q)
      IDLE_LO: begin
        if (sync_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end

      WAIT_HI: begin
        if (!sync_q) begin
          state_d = IDLE_LO;          // glitch rejected
        end else if (accept_hi) begin
          state_d = IDLE_HI;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      IDLE_HI: begin
        if (!sync_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end

      WAIT_LO: begin
        if (sync_q) begin
          state_d = IDLE_HI;          // glitch rejected
        end else if (accept_lo) begin
          state_d = IDLE_LO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE_LO;
      end
    endcase
  end

  // Output logic (process 3 of 3). x_level only moves on an acceptance; the
  // pulses default to 0 so they last exactly one cycle.
  always_comb begin
    x_level_d = x_level_q;
    x_press_d = 1'b0;

    case (state_q)
      IDLE_LO, IDLE_HI: begin
        x_level_d = x_level_q;
      end

      WAIT_HI: begin
        if (accept_hi) begin
          x_level_d = 1'b1;
          x_press_d = 1'b1;
        end
      end

      WAIT_LO: begin
        if (accept_lo) begin
          x_level_d = 1'b0;
        end
      end

      default: begin
        // Unreachable with a fully decoded 2-bit state, but recover to a
        // quiet output alongside the return to IDLE_LO.
        x_level_d = 1'b0;
        x_press_d = 1'b0;
      end
    endcase
  end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  // Release pulse: registered alongside x_level so it rises on the same edge
  // that x_level falls.
  logic x_release_q;
  logic x_release_d;

  always_comb begin
    x_release_d = accept_lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_release_q <= 1'b0;
    end else begin
      x_release_q <= x_release_d;
    end
  end

  assign x_release = x_release_q;
`else
  assign x_release = 1'b0;
`endif

  assign x_level = x_level_q;
  assign x_press = x_press_q;

endmodule : btn_debounce_fsm

// File: tb/tb_btn_debounce_fsm.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_fsm
//
// Directed self-checking bench for btn_debounce_fsm with default parameters
// (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 10 ns clock). Edge numbering: after the
// bench changes btn_raw just past a rising edge, the next rising edge is
// edge 1; outputs are sampled 1 ns after each edge. With defaults x_level
// moves on edge 6.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btn_debounce_fsm;
  import debounce_pkg::*;

  logic clk;
  logic reset;
  logic btn_raw;
  logic x_level;
  logic x_press;
  logic x_release;

  int n_checks;
  int n_fail;

  btn_debounce_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .x_level   (x_level),
    .x_press   (x_press),
    .x_release (x_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive btn_raw low long enough to settle in IDLE_LO, then confirm.
  task automatic settle_low();
    btn_raw = 1'b0;
    repeat (10) step();
    n_checks++;
    if (x_level !== 1'b0) begin
      n_fail++;
      $display("FAIL settle_low x_level: got %b want 0", x_level);
    end
  endtask

  // 1. Reset with btn_raw=1, then rise 6 edges after release.
  task automatic test_reset();
    reset   = 1'b1;
    btn_raw = 1'b1;
    #10;
    n_checks++;
    if ({x_level, x_press, x_release} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000", {x_level, x_press, x_release});
    end
    step();
    n_checks++;
    if ({x_level, x_press, x_release} !== 3'b000 || dut.state_q !== IDLE_LO) begin
      n_fail++;
      $display("FAIL reset_hold: outs %b state %0d want 000 state 0",
               {x_level, x_press, x_release}, dut.state_q);
    end
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_checks++;
      if (x_level !== (i >= 6) || x_press !== (i == 6)) begin
        n_fail++;
        $display("FAIL reset_rise edge %0d: level %b press %b want %b %b",
                 i, x_level, x_press, (i >= 6), (i == 6));
      end
    end
  endtask

  // 5. Release from x_level=1: fall on edge 6 with optional release pulse.
  task automatic test_release();
    logic exp_rel;
    btn_raw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      exp_rel = (i == 6);
`else
      exp_rel = 1'b0;
`endif
      n_checks++;
      if (x_level !== (i < 6) || x_release !== exp_rel || x_press !== 1'b0) begin
        n_fail++;
        $display("FAIL release edge %0d: level %b rel %b press %b want %b %b 0",
                 i, x_level, x_release, x_press, (i < 6), exp_rel);
      end
    end
  endtask

  // 2. Clean press held 100 ns.
  task automatic test_clean_press();
    btn_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_checks++;
      if (x_level !== (i >= 6) || x_press !== (i == 6) || x_release !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: level %b press %b rel %b want %b %b 0",
                 i, x_level, x_press, x_release, (i >= 6), (i == 6));
      end
    end
  endtask

  // 3. Bounce: 20 ns high / 10 ns low x5, then held high.
  task automatic test_bounce();
    int presses;
    presses = 0;
    for (int r = 0; r < 5; r++) begin
      btn_raw = 1'b1;
      step(); presses += int'(x_press);
      step(); presses += int'(x_press);
      btn_raw = 1'b0;
      step(); presses += int'(x_press);
    end
    n_checks++;
    if (presses !== 0 || x_level !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_reject: presses %0d level %b want 0 0", presses, x_level);
    end
    btn_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_checks++;
      if (x_level !== (i >= 6) || x_press !== (i == 6)) begin
        n_fail++;
        $display("FAIL bounce_accept edge %0d: level %b press %b want %b %b",
                 i, x_level, x_press, (i >= 6), (i == 6));
      end
    end
  endtask

  // 4. Glitch boundary: 3 samples rejected, exactly 4 accepted.
  task automatic test_glitch_boundary();
    int presses;
    int rises;
    btn_raw = 1'b1;
    repeat (3) step();
    btn_raw = 1'b0;
    presses = 0;
    rises   = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      presses += int'(x_press);
      rises   += int'(x_level);
    end
    n_checks++;
    if (presses !== 0 || rises !== 0) begin
      n_fail++;
      $display("FAIL glitch_3: presses %0d level_hi_cycles %0d want 0 0", presses, rises);
    end

    // Four raw cycles -> four sync_q samples -> accepted on edge 6, then the
    // low level that follows is itself accepted on edge 10.
    btn_raw = 1'b1;
    presses = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 4) btn_raw = 1'b0;
      presses += int'(x_press);
      if (i == 6) begin
        n_checks++;
        if (x_level !== 1'b1 || x_press !== 1'b1) begin
          n_fail++;
          $display("FAIL glitch_4_accept: level %b press %b want 1 1", x_level, x_press);
        end
      end
      if (i == 10) begin
        n_checks++;
        if (x_level !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch_4_fall: level %b want 0", x_level);
        end
      end
    end
    n_checks++;
    if (presses !== 1) begin
      n_fail++;
      $display("FAIL glitch_4_count: presses %0d want 1", presses);
    end
  endtask

  // 6. Reset while WAIT_HI with cnt=2.
  task automatic test_reset_mid_wait();
    btn_raw = 1'b1;
    repeat (4) step();
    n_checks++;
    if (dut.state_q !== WAIT_HI || dut.cnt_q !== 8'd2) begin
      n_fail++;
      $display("FAIL mid_wait_setup: state %0d cnt %0d want 1 2", dut.state_q, dut.cnt_q);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (dut.state_q !== IDLE_LO || dut.cnt_q !== 8'd0 || x_level !== 1'b0 || x_press !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait_reset: state %0d cnt %0d level %b press %b want 0 0 0 0",
               dut.state_q, dut.cnt_q, x_level, x_press);
    end
    step();
    n_checks++;
    if (x_press !== 1'b0 || x_level !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait_hold: level %b press %b want 0 0", x_level, x_press);
    end
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_checks++;
      if (x_level !== (i >= 6) || x_press !== (i == 6)) begin
        n_fail++;
        $display("FAIL mid_wait_recover edge %0d: level %b press %b want %b %b",
                 i, x_level, x_press, (i >= 6), (i == 6));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_release();
    test_clean_press();
    test_release();
    test_bounce();
    settle_low();
    test_glitch_boundary();
    settle_low();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_btn_debounce_fsm
